accumulator_sequencer: RTL

Sequences the three-stage pre-adder/accumulator datapath (operand register, adder, accumulate) for neuron-by-neuron summation. Accepts a job of `n_groups` groups of `n_terms` operand pairs each, streams the pairs into the datapath, drives its clock enables and clear controls, and presents each group's final sum with a valid/ready handshake. Sits between the operand fetch logic and the neuron update stage.

---
 rtl/accumulator_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/accumulator_sequencer.sv
// Sequencer for a three-stage pre-adder/accumulator: feeds operand pairs group by group,
// drives the stage enables/clears and presents each group's sum with a valid/ready handshake.
module accumulator_sequencer #(
  parameter int SIZEIN = 16,
  parameter int TERM_W = 10,
  parameter int GRP_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [TERM_W-1:0]          n_terms,
  input  logic [GRP_W-1:0]           n_groups,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SIZEIN-1:0]   in_a,
  input  logic signed [SIZEIN-1:0]   in_b,
  output logic signed [SIZEIN-1:0]   acc_a,
  output logic signed [SIZEIN-1:0]   acc_b,
  output logic                       acc_ce1,
  output logic                       acc_ce2,
  output logic                       acc_ce3,
  output logic                       acc_clear_and_go,
  output logic                       acc_clear,
  input  logic signed [2*SIZEIN-1:0] acc_p,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [2*SIZEIN-1:0] res_data,
  output logic [GRP_W-1:0]           res_idx,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [TERM_W-1:0] terms_q, terms_d, term_q, term_d;
  logic [GRP_W-1:0]  groups_q, groups_d, grp_q, grp_d, res_idx_q, res_idx_d;
  logic              s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic              s2_v_q, s2_v_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic              res_valid_q, res_valid_d, done_q, done_d;

  logic start_ok, start_zero, adv, accept, term_last, grp_last, hs, final_hs, ce3_last;

  assign start_ok   = (state_q == IDLE) && start && (n_terms != '0) && (n_groups != '0);
  assign start_zero = (state_q == IDLE) && start && ((n_terms == '0) || (n_groups == '0));
  assign hs         = res_valid_q && res_ready;
  // Only a group's first term (a load) would destroy the pending result in acc_p.
  assign adv        = !(s2_v_q && s2_first_q && res_valid_q && !res_ready);
  assign accept     = in_valid && (state_q == RUN) && adv;
  assign term_last  = (term_q == terms_q - TERM_W'(1));
  assign grp_last   = (grp_q == groups_q - GRP_W'(1));
  assign final_hs   = hs && (res_idx_q == groups_q - GRP_W'(1));
  assign ce3_last   = s2_v_q && adv && s2_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (accept && term_last && grp_last) state_d = DRAIN;
      DRAIN:   if (final_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready         = (state_q == RUN) && adv;
    acc_a            = in_a;
    acc_b            = in_b;
    acc_ce1          = accept;
    acc_ce2          = s1_v_q && adv;
    acc_ce3          = s2_v_q && adv;
    acc_clear_and_go = s2_v_q && adv && s2_first_q;
    acc_clear        = start_ok;
    res_valid        = res_valid_q;
    res_data         = res_valid_q ? acc_p : '0;
    res_idx          = res_idx_q;
    busy             = (state_q != IDLE);
    done             = done_q || ((state_q == DRAIN) && final_hs);
  end

  always_comb begin
    terms_d     = terms_q;
    groups_d    = groups_q;
    term_d      = term_q;
    grp_d       = grp_q;
    s1_v_d      = s1_v_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s2_v_d      = s2_v_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    res_valid_d = res_valid_q;
    res_idx_d   = res_idx_q;
    done_d      = start_zero;
    if (start_ok) begin
      terms_d   = n_terms;
      groups_d  = n_groups;
      term_d    = '0;
      grp_d     = '0;
      res_idx_d = '0;
    end
    if (accept) begin
      if (term_last) begin
        term_d = '0;
        grp_d  = grp_q + GRP_W'(1);
      end else begin
        term_d = term_q + TERM_W'(1);
      end
    end
    // Tags mirror the datapath operand (s1) and adder (s2) registers.
    if (adv) begin
      s2_v_d     = s1_v_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s1_v_d     = accept;
      s1_first_d = (term_q == '0);
      s1_last_d  = term_last;
    end
    if (hs) begin
      res_valid_d = 1'b0;
      res_idx_d   = res_idx_q + GRP_W'(1);
    end
    if (ce3_last) res_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      terms_q     <= '0;
      groups_q    <= '0;
      term_q      <= '0;
      grp_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      terms_q     <= terms_d;
      groups_q    <= groups_d;
      term_q      <= term_d;
      grp_q       <= grp_d;
      s1_v_q      <= s1_v_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s2_v_q      <= s2_v_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      done_q      <= done_d;
    end
  end

endmodule
